// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, sequencer state type and digit decode
//
// Purpose: constants and helpers shared by the RPN key sequencer and its
// multiplier. Key codes are the raw 5-bit numpad values (bit4 = valid).
package calc_pkg;

  localparam logic [4:0] KEY_1     = 5'b10000;
  localparam logic [4:0] KEY_4     = 5'b10001;
  localparam logic [4:0] KEY_7     = 5'b10010;
  localparam logic [4:0] KEY_0     = 5'b10011;
  localparam logic [4:0] KEY_2     = 5'b10100;
  localparam logic [4:0] KEY_5     = 5'b10101;
  localparam logic [4:0] KEY_8     = 5'b10110;
  localparam logic [4:0] KEY_3     = 5'b11000;
  localparam logic [4:0] KEY_6     = 5'b11001;
  localparam logic [4:0] KEY_9     = 5'b11010;
  localparam logic [4:0] KEY_ENTER = 5'b11100;
  localparam logic [4:0] KEY_ADD   = 5'b11101;
  localparam logic [4:0] KEY_SUB   = 5'b11110;
  localparam logic [4:0] KEY_MUL   = 5'b11111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_MUL,
    ST_ISSUE,
    ST_RELEASE
  } state_e;

  function automatic logic is_digit(input logic [4:0] code);
    case (code)
      KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
      KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: is_digit = 1'b1;
      default:                           is_digit = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] digit_of(input logic [4:0] code);
    case (code)
      KEY_1:   digit_of = 4'd1;
      KEY_2:   digit_of = 4'd2;
      KEY_3:   digit_of = 4'd3;
      KEY_4:   digit_of = 4'd4;
      KEY_5:   digit_of = 4'd5;
      KEY_6:   digit_of = 4'd6;
      KEY_7:   digit_of = 4'd7;
      KEY_8:   digit_of = 4'd8;
      KEY_9:   digit_of = 4'd9;
      default: digit_of = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/calc_seq_mul.sv
// rtl/calc_seq_mul.sv - iterative shift-add multiplier, one bit per cycle
//
// Ports:
//   clock, reset (sync, active-low; aborts a running operation)
//   start   : load a and b and begin
//   a, b    : operands
//   done    : single-cycle pulse exactly WIDTH cycles after start
//   product : low WIDTH bits of a*b, valid while done=1
module calc_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] sum;

  // The final step's sum is presented combinationally so done lands
  // WIDTH cycles after start rather than one cycle later.
  assign sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = run_q && (cnt_q == CW'(1));
  assign product = sum;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = a;
      mplier_d = b;
      cnt_d    = CW'(WIDTH);
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/calc_key_sequencer.sv
// rtl/calc_key_sequencer.sv - debounced one-command-per-press RPN key sequencer
//
// Ports:
//   clock, reset (sync, active-low)
//   key         : numpad code, bit4 = valid
//   top, next   : stack top and second element
//   count       : stack element count
//   stack_push, stack_pop, stack_write : one-cycle registered strobes
//   new_value   : value for stack_write
//   busy        : high whenever not IDLE
//   op_error    : sticky flag for the last rejected command
module calc_key_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int COUNT_BITS    = 6,
  parameter int MAX_COUNT     = 32,
  parameter int STABLE_CYCLES = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            key,
  input  logic [WIDTH-1:0]      top,
  input  logic [WIDTH-1:0]      next,
  input  logic [COUNT_BITS-1:0] count,
  output logic                  stack_push,
  output logic                  stack_pop,
  output logic                  stack_write,
  output logic [WIDTH-1:0]      new_value,
  output logic                  busy,
  output logic                  op_error
);

  localparam int              SW          = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0]   STABLE_LAST = SW'(STABLE_CYCLES - 1);
  localparam int              EW          = WIDTH + 4;

  state_e           state_q, state_d;
  logic [4:0]       key_prev_q, code_q, code_d;
  logic [SW-1:0]    stab_q, stab_d;
  logic             push_q, push_d, pop_q, pop_d, write_q, write_d, err_q, err_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             stable, few_ops, mul_start, mul_done;
  logic [EW-1:0]    dig_ext;
  logic [WIDTH-1:0] mul_product;

  calc_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (mul_start),
    .a       (next),
    .b       (top),
    .done    (mul_done),
    .product (mul_product)
  );

  // stab_q = run length of key_prev_q minus one, saturating; stable means
  // the previous STABLE_CYCLES samples were identical.
  assign stable  = (stab_q == STABLE_LAST);
  // Four extra bits hold top*10+9 exactly, so any carry out is an overflow.
  assign dig_ext = EW'(top) * EW'(10) + EW'(digit_of(code_q));
  assign few_ops = (count < COUNT_BITS'(2));

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    push_d    = 1'b0;
    pop_d     = 1'b0;
    write_d   = 1'b0;
    value_d   = value_q;
    err_d     = err_q;
    mul_start = 1'b0;
    if (key != key_prev_q)   stab_d = '0;
    else if (stable)         stab_d = stab_q;
    else                     stab_d = stab_q + SW'(1);

    case (state_q)
      ST_IDLE: begin
        if (stable && key_prev_q[4]) begin
          state_d = ST_DECODE;
          code_d  = key_prev_q;
        end
      end
      ST_DECODE: begin
        state_d = ST_ISSUE;
        if (is_digit(code_q)) begin
          if (count == '0 || (|dig_ext[EW-1:WIDTH])) err_d = 1'b1;
          else begin
            write_d = 1'b1;
            value_d = dig_ext[WIDTH-1:0];
            err_d   = 1'b0;
          end
        end else begin
          case (code_q)
            KEY_ENTER: begin
              if (count >= COUNT_BITS'(MAX_COUNT)) err_d = 1'b1;
              else begin
                push_d = 1'b1;
                err_d  = 1'b0;
              end
            end
            KEY_ADD, KEY_SUB: begin
              if (few_ops) err_d = 1'b1;
              else begin
                pop_d   = 1'b1;
                write_d = 1'b1;
                value_d = (code_q == KEY_ADD) ? next + top : next - top;
                err_d   = 1'b0;
              end
            end
            KEY_MUL: begin
              if (few_ops) err_d = 1'b1;
              else begin
                mul_start = 1'b1;
                state_d   = ST_MUL;
              end
            end
            // Unmapped codes still pass through ISSUE/RELEASE silently.
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_ISSUE;
          pop_d   = 1'b1;
          write_d = 1'b1;
          value_d = mul_product;
          err_d   = 1'b0;
        end
      end
      ST_ISSUE:   state_d = ST_RELEASE;
      ST_RELEASE: if (stable && !key_prev_q[4]) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      key_prev_q <= '0;
      code_q     <= '0;
      stab_q     <= '0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      write_q    <= 1'b0;
      value_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key;
      code_q     <= code_d;
      stab_q     <= stab_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      write_q    <= write_d;
      value_q    <= value_d;
      err_q      <= err_d;
    end
  end

  assign stack_push  = push_q;
  assign stack_pop   = pop_q;
  assign stack_write = write_q;
  assign new_value   = value_q;
  assign op_error    = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_key_sequencer.sv
// tb/tb_calc_key_sequencer.sv - directed self-checking bench for calc_key_sequencer
module tb_calc_key_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  key;
  logic [31:0] top, next;
  logic [5:0]  count;
  logic        stack_push, stack_pop, stack_write, busy, op_error;
  logic [31:0] new_value;

  always #10 clock = ~clock;

  calc_key_sequencer #(
    .WIDTH(32), .COUNT_BITS(6), .MAX_COUNT(32), .STABLE_CYCLES(4)
  ) dut (
    .clock(clock), .reset(reset), .key(key), .top(top), .next(next),
    .count(count), .stack_push(stack_push), .stack_pop(stack_pop),
    .stack_write(stack_write), .new_value(new_value), .busy(busy),
    .op_error(op_error)
  );

  int checks = 0;
  int errors = 0;

  // Results of the most recent press
  int          n_str, first, busy_first, consec;
  logic [31:0] val;
  logic        sp, spo, sw;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Hold code for 'hold' cycles, then release and wait for IDLE.
  task automatic press(input logic [4:0] code, input int hold);
    logic last, any;
    key = code; n_str = 0; first = 0; busy_first = 0; consec = 0;
    val = '0; sp = 0; spo = 0; sw = 0; last = 0;
    for (int i = 1; i <= hold + 6; i++) begin
      if (i == hold + 1) key = 5'b00000;
      @(posedge clock); #1;
      any = stack_push | stack_pop | stack_write;
      if (any) begin
        n_str++;
        if (last) consec++;
        if (first == 0) begin
          first = i; val = new_value;
          sp = stack_push; spo = stack_pop; sw = stack_write;
        end
      end
      last = any;
      if (busy && busy_first == 0) busy_first = i;
    end
  endtask

  int          pre_str, abort_first;
  logic [31:0] abort_val;
  logic [5:0]  rst_outs;
  logic [31:0] rst_val;

  initial begin
    reset = 1'b0; key = '0; top = '0; next = '0; count = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_push",  32'(stack_push),  32'd0);
    check_eq("rst_pop",   32'(stack_pop),   32'd0);
    check_eq("rst_write", 32'(stack_write), 32'd0);
    check_eq("rst_value", new_value,        32'd0);
    check_eq("rst_err",   32'(op_error),    32'd0);
    check_eq("rst_busy",  32'(busy),        32'd0);
    reset = 1'b1;

    // Digit 1 held 20 cycles: one write at acceptance+2 (edge 6)
    count = 1; top = 12;
    press(5'b10000, 20);
    check_eq("d1_nstr",  n_str, 1);
    check_eq("d1_cycle", first, 6);
    check_eq("d1_value", val, 32'd121);
    check_eq("d1_kind",  {29'd0, sp, spo, sw}, 32'b001);
    check_eq("d1_busy",  busy_first, 5);
    press(5'b10000, 20);
    check_eq("d1_again", n_str, 1);

    // + with one operand rejected, then ENTER accepted clears error
    press(5'b11101, 20);
    check_eq("add_rej_nstr", n_str, 0);
    check_eq("add_rej_err",  32'(op_error), 32'd1);
    press(5'b11100, 20);
    check_eq("enter_kind",  {29'd0, sp, spo, sw}, 32'b100);
    check_eq("enter_cycle", first, 6);
    check_eq("enter_err",   32'(op_error), 32'd0);

    // Subtract wraps
    count = 2; next = 5; top = 7;
    press(5'b11110, 20);
    check_eq("sub_nstr",  n_str, 1);
    check_eq("sub_kind",  {29'd0, sp, spo, sw}, 32'b011);
    check_eq("sub_value", val, 32'hFFFF_FFFE);

    // Multiply: strobe at acceptance+34 (edge 38)
    next = 65537; top = 65537;
    press(5'b11111, 45);
    check_eq("mul_nstr",   n_str, 1);
    check_eq("mul_cycle",  first, 38);
    check_eq("mul_value",  val, 32'h0002_0001);
    check_eq("mul_kind",   {29'd0, sp, spo, sw}, 32'b011);
    check_eq("mul_busy",   busy_first, 5);
    check_eq("mul_consec", consec, 0);

    // Digit overflow boundary
    count = 1; top = 429496729;
    press(5'b11001, 20);
    check_eq("ovf_nstr", n_str, 0);
    check_eq("ovf_err",  32'(op_error), 32'd1);
    press(5'b10101, 20);
    check_eq("max_value", val, 32'hFFFF_FFFF);
    check_eq("max_err",   32'(op_error), 32'd0);

    // Digit on empty stack rejected; ignored code keeps error, no strobe
    count = 0; top = 3;
    press(5'b10010, 20);
    check_eq("empty_err", 32'(op_error), 32'd1);
    press(5'b10111, 20);
    check_eq("ign_nstr", n_str, 0);
    check_eq("ign_err",  32'(op_error), 32'd1);
    check_eq("ign_busy", busy_first, 5);

    // ENTER at capacity rejected, one below accepted
    count = 32;
    press(5'b11100, 20);
    check_eq("full_nstr", n_str, 0);
    check_eq("full_err",  32'(op_error), 32'd1);
    count = 31;
    press(5'b11100, 20);
    check_eq("room_push", 32'(sp), 32'd1);

    // Add wraps
    count = 3; next = 32'hFFFF_FFFF; top = 2;
    press(5'b11101, 20);
    check_eq("add_value", val, 32'd1);
    check_eq("add_kind",  {29'd0, sp, spo, sw}, 32'b011);

    // Reset during MUL cycle 10 aborts; held key is then a fresh press
    count = 0;
    press(5'b11110, 20);
    count = 2; next = 3; top = 5;
    key = 5'b11111; pre_str = 0; abort_first = 0; abort_val = '0;
    rst_outs = '0; rst_val = '1;
    for (int i = 1; i <= 60; i++) begin
      if (i == 16) reset = 1'b0;
      if (i == 17) reset = 1'b1;
      @(posedge clock); #1;
      if (i == 16) begin
        rst_outs = {stack_push, stack_pop, stack_write, op_error, busy, 1'b0};
        rst_val  = new_value;
      end
      if (stack_push | stack_pop | stack_write) begin
        if (abort_first == 0) begin
          abort_first = i; abort_val = new_value;
        end else pre_str++;
      end
    end
    key = 5'b00000;
    repeat (8) @(posedge clock);
    check_eq("abort_outs",  32'(rst_outs), 32'd0);
    check_eq("abort_value", rst_val, 32'd0);
    check_eq("abort_first", abort_first, 54);
    check_eq("abort_prod",  abort_val, 32'd15);
    check_eq("abort_extra", pre_str, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_key_sequencer.md
Name: calc_key_sequencer

Overview:
Command sequencer between the numpad scanner and the operand stack of the RPN calculator. It filters numpad codes for stability and accepts exactly one command per key press. It checks operand-count preconditions, runs multiply on an iterative shift-add unit, and issues one-cycle push/pop/write strobes plus the new value to the stack. It replaces the ad-hoc level-driven decode in the top level. Level-driven decode re-fires every clock while a key is held.

Parameters:
WIDTH, 32, data width of stack elements and new_value
COUNT_BITS, 6, width of stack element count
MAX_COUNT, 32, stack capacity; push refused at this count
STABLE_CYCLES, 1000, consecutive identical key samples required to accept a press or a release

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-low reset
key  in  5  numpad code; bit4 = key valid, bits3:0 = key id
top  in  WIDTH  stack top element
next  in  WIDTH  stack second element
count  in  COUNT_BITS  stack element count
stack_push  out  1  one-cycle strobe: push a new zero element
stack_pop  out  1  one-cycle strobe: remove top
stack_write  out  1  one-cycle strobe: write new_value to top (after pop when both asserted)
new_value  out  WIDTH  value for stack_write, valid while stack_write=1
busy  out  1  high in every state except IDLE
op_error  out  1  set on a rejected command; cleared by reset or by the next successfully executed command

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE; all strobes=0; new_value=0; op_error=0; stability counter=0; any multiply in progress is aborted with no strobes issued.
- Key map: 10000=1, 10001=4, 10010=7, 10011=0, 10100=2, 10101=5, 10110=8, 11000=3, 11001=6, 11010=9, 11100=A (enter/push), 11101=B (+), 11110=C (-), 11111=D (*). Codes 10111 and 11011 are ignored: no strobe, no error; the FSM still waits for release.
- Stability filter: counter resets whenever key differs from the previous sample. "Accepted" = key valid and unchanged for STABLE_CYCLES samples while in IDLE.
- FSM states: IDLE, DECODE, MUL, ISSUE, RELEASE.
  - IDLE -> DECODE on the acceptance cycle (cycle A).
  - DECODE (A+1): latch top, next, count and key id; evaluate preconditions.
  - DECODE -> ISSUE for digit, A, B, C and for rejected commands.
  - DECODE -> MUL for an accepted D.
  - MUL: runs WIDTH cycles; -> ISSUE on done.
  - ISSUE: exactly one strobe cycle (A+2; WIDTH+A+2 for multiply); -> RELEASE.
  - RELEASE: wait until key bit4=0 for STABLE_CYCLES consecutive samples; -> IDLE.
- Key changes while in DECODE, MUL, ISSUE or RELEASE are ignored; at most one command per physical press.
- Commands (all arithmetic is modulo 2^WIDTH unless stated):
  - Digit d: stack_write=1, new_value=top*10+d.
    - Rejected (op_error=1, no strobe) if the exact result exceeds 2^WIDTH-1.
    - Rejected if count=0.
  - A: stack_push=1. Rejected if count=MAX_COUNT.
  - B: stack_pop=1, stack_write=1, new_value=next+top (wraps).
  - C: stack_pop=1, stack_write=1, new_value=next-top (wraps).
  - D: stack_pop=1, stack_write=1, new_value=low WIDTH bits of next*top.
  - B, C and D are rejected if count<2.
- A rejected command produces an ISSUE cycle with all strobes 0 and op_error set in that cycle.
- An accepted command clears op_error in its ISSUE cycle.
- Strobes and new_value are registered outputs.
- Strobes are never asserted outside ISSUE and never for two consecutive cycles.

Decomposition:
- Shared package calc_pkg holds:
  - key code constants (KEY_0..KEY_9, KEY_ENTER, KEY_ADD, KEY_SUB, KEY_MUL);
  - the state enum;
  - the digit-decode function (code -> 0..9).
- One sub-module, calc_seq_mul: shift-add multiplier.
  - Ports: clock, reset, start, a, b, done, product (low WIDTH bits).
  - done is a single pulse exactly WIDTH cycles after start.
  - A reset pulse aborts an operation in progress.

Test Plan:
- STABLE_CYCLES=4, count=1, top=12. Hold key 10000 for 20 cycles -> exactly one stack_write, new_value=121, at acceptance+2. No further strobe until release plus a new press.
- count=1. Press 11101 (+) -> no strobes, op_error=1. Then press A with count=1 -> stack_push pulse, op_error=0.
- count=2, next=5, top=7. Press C -> stack_pop=stack_write=1 in the same cycle, new_value=0xFFFFFFFE.
- count=2, next=65537, top=65537. Press D -> busy high for 34 cycles. Single pop+write at acceptance+34, new_value=0x00020001.
- top=429496729. Digit 6 -> op_error=1, no write. Digit 5 -> write, new_value=4294967295.
- Press D, then assert reset=0 for one cycle at MUL cycle 10 -> no strobes ever issued. All outputs 0 and state IDLE the cycle after the reset edge. Key held through reset is accepted as a fresh press.
